// File: rtl/Public_Info.sv
// Shared pipeline types: decoded instruction bundle and issue-queue sizing.
package Public_Info;

   localparam int unsigned IQ_DEPTH = 8;

   typedef struct packed {
      logic [31:0] PC;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic        o_valid;
   } PC_set;

   // Number of set bits in a two-bit valid vector.
   function automatic logic [1:0] popcnt2(input logic [1:0] v);
      return 2'(v[1]) + 2'(v[0]);
   endfunction

endpackage

// File: rtl/issue_queue_mem.sv
// Issue-queue storage: DEPTH x PC_set register file, two write ports, two async read ports.
module issue_queue_mem
   import Public_Info::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we0,
   input  logic [PTR_W-1:0] waddr0,
   input  PC_set            wdata0,
   input  logic             we1,
   input  logic [PTR_W-1:0] waddr1,
   input  PC_set            wdata1,
   input  logic [PTR_W-1:0] raddr0,
   input  logic [PTR_W-1:0] raddr1,
   output PC_set            rdata0,
   output PC_set            rdata1
);

   PC_set mem [DEPTH];

   // Contents are never reset; validity is tracked by the pointers in the top.
   always_ff @(posedge clk) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/issue_queue.sv
// Dual-issue instruction queue between decode and dispatch: 2-wide push, 0..2 pop, flush.
module issue_queue
   import Public_Info::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_flush,
   input  PC_set            i_set1,
   input  PC_set            i_set2,
   input  logic [1:0]       i_push_valid,
   output logic             o_ready,
   output PC_set            o_set1,
   output PC_set            o_set2,
   output logic [1:0]       o_is_valid,
   input  logic [1:0]       i_usingNUM,
   output logic [CNT_W-1:0] o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic [1:0]       npush, npop, req, avail;
   logic             accept, we0, we1;
   PC_set            wdata0, wdata1, rd0, rd1;

   assign o_ready    = count <= CNT_W'(DEPTH - 2);
   assign o_is_valid = {count >= CNT_W'(1), count >= CNT_W'(2)};
   assign o_count    = count;

   // Push compaction, pop clamping and output valid override.
   always_comb begin
      accept = o_ready && rstn && !i_flush;
      npush  = o_ready ? popcnt2(i_push_valid) : 2'd0;
      req    = (i_usingNUM == 2'd3) ? 2'd2 : i_usingNUM;
      avail  = o_is_valid[0] ? 2'd2 : (o_is_valid[1] ? 2'd1 : 2'd0);
      npop   = (req < avail) ? req : avail;
      we0    = accept && (i_push_valid != 2'b00);
      we1    = accept && (i_push_valid == 2'b11);
      wdata0 = i_push_valid[1] ? i_set1 : i_set2;
      wdata1 = i_set2;
      o_set1 = rd0;
      o_set2 = rd1;
      o_set1.o_valid = o_is_valid[1];
      o_set2.o_valid = o_is_valid[0];
   end

   // Reset takes precedence over flush; both empty the queue.
   always_ff @(posedge clk) begin
      if (!rstn || i_flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(npop);
         tail  <= tail + PTR_W'(npush);
         count <= count + CNT_W'(npush) - CNT_W'(npop);
      end
   end

   issue_queue_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk    (clk),
      .we0    (we0),
      .waddr0 (tail),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (tail + PTR_W'(1)),
      .wdata1 (wdata1),
      .raddr0 (head),
      .raddr1 (head + PTR_W'(1)),
      .rdata0 (rd0),
      .rdata1 (rd1)
   );

endmodule

// File: doc/issue_queue.md
# issue_queue

Dual-issue instruction queue between decode and `Issue_dispatch`. It buffers decoded `PC_set` entries, accepts up to two per cycle from decode, and presents the two oldest to dispatch. It retires 0, 1 or 2 entries per cycle according to the dispatch consumption count. It also generates back-pressure to decode and clears on pipeline flush.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; must be a power of two and at least 4.
- `CNT_W`, `$clog2(DEPTH)+1`, width of the occupancy counter.

Ports:
- `clk` input 1: the single clock.
- `rstn` input 1: synchronous, active-low reset.
- `i_flush` input 1: pipeline flush, synchronous.
- `i_set1` input `PC_set`: older decoded instruction.
- `i_set2` input `PC_set`: younger decoded instruction.
- `i_push_valid` input 2: bit1 qualifies `i_set1`, bit0 qualifies `i_set2`.
- `o_ready` output 1: queue can accept a full pair this cycle.
- `o_set1` output `PC_set`: entry at head.
- `o_set2` output `PC_set`: entry at head+1.
- `o_is_valid` output 2: {head valid, head+1 valid}; drives dispatch `i_is_valid`.
- `i_usingNUM` input 2: entries consumed by dispatch this cycle (0..2).
- `o_count` output `CNT_W`: current occupancy.

## Operation
- Storage: `DEPTH` `PC_set` entries, with head pointer, tail pointer and count registers. Pointers are `$clog2(DEPTH)` bits wide and wrap naturally modulo `DEPTH`.
- `o_ready` = (count <= DEPTH-2). It is combinational from the count register only.
- Push, only when `o_ready`=1:
  - `npush` = popcount(`i_push_valid`).
  - Pushes are compacted, with `i_set1` first. 2'b11 writes set1 at tail and set2 at tail+1. 2'b10 writes set1 at tail. 2'b01 writes set2 at tail.
  - tail advances by `npush`.
  - When `o_ready`=0 the push is ignored; decode holds its inputs.
- Pop:
  - `npop` = min(`i_usingNUM`, number of valid outputs).
  - head advances by `npop`.
  - `i_usingNUM`=3 is treated as 2, then clamped.
  - Over-consumption is clamped, and the bench flags it with an assertion.
- Counting on simultaneous push/pop: count_next = count + npush − npop.
- Pop acts only on entries present at cycle start. A freshly pushed entry is never visible in the same cycle (no bypass).
- Outputs:
  - `o_set1` = mem[head] and `o_set2` = mem[head+1], combinational reads.
  - The `o_valid` field of each output is forced to the matching `o_is_valid` bit; all other fields pass through.
  - `o_is_valid` = {count>=1, count>=2}.
- Combinational loop: none. Outputs depend only on registers. `i_usingNUM` affects only next-state logic.
- Flush: `i_flush`=1 zeroes head, tail and count next edge, overriding any same-cycle push or pop. Memory contents are not cleared.
- Reset: `rstn`=0 at an edge has the same effect as flush and overrides flush. Mid-operation reset discards all entries.

## Timing
- Push-to-visible latency: 1 cycle. A pair pushed at edge N appears on `o_set1`/`o_set2` after edge N.
- Pop takes effect at the next edge. The next pair is presented in the following cycle.
- Reset values:
  - head=0, tail=0, count=0.
  - `o_is_valid`=2'b00, `o_count`=0, `o_ready`=1.
  - `o_set*.o_valid`=0.
- Empty: `o_is_valid`=00; any `i_usingNUM` pops nothing.
- One entry: `o_is_valid`=10; `i_usingNUM`=2 pops 1.
- Full threshold: at count=DEPTH-1 or DEPTH, `o_ready`=0. Pops in that cycle still execute, and `o_ready` reasserts the cycle after count falls to DEPTH-2.
- Wrap: head=DEPTH-1 gives `o_set2` = mem[0]. A two-entry push at tail=DEPTH-1 writes mem[DEPTH-1] and mem[0].

## Structure
- `PC_set` comes from `Public_Info`. Add the `IQ_DEPTH` constant to `Public_Info`, together with a `popcnt2` function used for `npush`.
- One sub-module, `issue_queue_mem`:
  - `DEPTH`×`PC_set` register file.
  - Two write ports, with enables and addresses.
  - Two asynchronous read ports.
- The top level holds the pointers, count, clamp, ready and flush logic.

## Test plan
- Reset then push 2'b11 with PCs 0x1c000000/0x1c000004 → next cycle `o_is_valid`=11 and `o_count`=2; `i_usingNUM`=2 → next cycle `o_is_valid`=00 and `o_count`=0.
- Push 2'b01 (PC 0x1c000010) into an empty queue → `o_set1.PC`=0x1c000010 and `o_is_valid`=10; `i_usingNUM`=2 → count 0, no underflow.
- DEPTH=8: fill with four pair pushes, then hold a push asserted for 5 cycles → `o_ready` deasserts at count=7/8 (not at 6), count stays 8, no entry is overwritten. A `i_usingNUM`=2 pop at count 8 → count 6 after that edge, `o_ready`=1 from then on, and the held pair is accepted at the following edge, giving count 8.
- Simultaneous push 11 and pop 1 at count 3 → count 4, program order preserved across the head/tail wrap at index 7→0.
- `i_flush` together with push 11 and pop 2 at count 5 → count 0, `o_is_valid`=00, tail=head=0.
- `rstn`=0 asserted with `i_flush`=0 at count 6 → all outputs at reset values next cycle; a push in the following cycle appears at mem[0].
